data_memory_pipelined: RTL and testbench
========================================

// Module: data_memory_pipelined
// PURPOSE
//  Parametrised word-addressed data memory for the CPU load/store path, next generation of the
//  single-port data RAM. Adds valid/ready request handshake, per-byte write strobes, configurable
//  read latency, address-range/alignment checking and a hardware clear sequence after reset.
// PARAMETERS
//  WIDTH    64   data word width in bits; multiple of 8, power of two (BYTES = WIDTH/8)
//  DEPTH    64   number of words; power of two, >= 2
//  ADDR_W   64   byte-address width
//  RD_LAT   2    cycles from request acceptance to response; legal range 1..4
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst_n      in   1         synchronous active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request this cycle
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   WIDTH     write data
//  req_be     in   BYTES     byte enables for writes (bit i -> byte i); ignored on reads
//  rsp_valid  out  1         response valid (one cycle per accepted request)
//  rsp_rdata  out  WIDTH     read data; 0 for writes and errored requests
//  rsp_err    out  1         request was misaligned or out of range
// BEHAVIOUR
//  - Reset: rst_n=0 at a posedge -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline
//    flushed, FSM -> CLEAR with clear counter = 0. Applies mid-operation; in-flight responses dropped.
//  - FSM CLEAR: writes 0 to word[cnt] each cycle, cnt++; req_ready=0. After word DEPTH-1 is
//    written -> RUN. CLEAR lasts exactly DEPTH cycles after reset release.
//  - FSM RUN: req_ready=1 every cycle; no backpressure on responses (no rsp_ready).
//  - Accept = req_valid & req_ready at posedge. Requests with req_ready=0 are ignored, not queued.
//  - Index = req_addr >> log2(BYTES). err = (req_addr[log2(BYTES)-1:0] != 0) | (index >= DEPTH)
//    (upper address bits included in range check, no wrap-around/aliasing).
//  - Write, no err: at accept edge, byte i of word[index] <= req_wdata byte i where req_be[i]=1;
//    other bytes unchanged. req_be=0 is a legal no-op write. Errored write: memory unchanged.
//  - Read: data sampled at accept edge after any same-edge write commit; a read accepted the cycle
//    after a write to the same word returns the new data. Errored read returns 0.
//  - Response: rsp_valid=1 exactly RD_LAT cycles after the accept edge, for reads and writes,
//    in order, one per accepted request; back-to-back accepts give back-to-back responses.
//    rsp_err reflects err; rsp_rdata=0 whenever rsp_valid=0 or response is a write/error.
//  - Throughput: one request per cycle in RUN; at most RD_LAT requests in flight.
// TESTING
//  1 Reset release, DEPTH=64 -> req_ready=0 for 64 cycles then 1; read every word -> all 0, err=0.
//  2 Write addr 0x10 data 0x1122334455667788 be=0xFF, read 0x10 next cycle -> rsp_rdata same,
//    read response exactly RD_LAT cycles after its accept; write response rdata=0.
//  3 Over word 0x1122334455667788 at 0x10, write 0xAAAAAAAAAAAAAAAA be=0x0F -> read 0x11223344AAAAAAAA.
//  4 Read addr 0x13 (misaligned) and 0x200 (index 64) -> rsp_err=1, rdata=0; write to 0x200
//    does not alter word 0 (no aliasing).
//  5 Eight back-to-back reads, RD_LAT=1,2,4 -> eight consecutive rsp_valid pulses, in order.
//  6 rst_n=0 with 2 reads in flight -> rsp_valid=0 next cycle, no stale responses, CLEAR reruns.

Source files
------------

// File: rtl/data_memory_pipelined.sv
// Word-addressed data memory for the load/store path.
// Requests use a valid/ready handshake and carry per-byte write strobes.
// Responses come out of a fixed-latency pipeline.
// Misaligned and out-of-range requests are flagged rather than aliased.
// After reset the array is zero-filled one word per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_CLEAR | zero-filling word[clr_cnt], requests refused
// ST_RUN   | accepting one request per cycle, responses RD_LAT later
module data_memory_pipelined #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 64,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [WIDTH-1:0]    req_wdata,
   input  logic [WIDTH/8-1:0]  req_be,
   output logic                rsp_valid,
   output logic [WIDTH-1:0]    rsp_rdata,
   output logic                rsp_err
);

   localparam int BYTES = WIDTH / 8;
   localparam int BOFF  = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              clr_we;

   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] word_addr;
   logic [IDX_W-1:0]  req_idx;
   logic [WIDTH-1:0]  rd_word;

   logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0] pipe_err_q, pipe_err_d;
   logic [WIDTH-1:0]  pipe_dat_q [RD_LAT];
   logic [WIDTH-1:0]  pipe_dat_d [RD_LAT];

   // Next-state logic: sweep the clear counter once, then sit in RUN
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      req_ready = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            req_ready = 1'b1;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Address decode: the full upper address takes part in the range check, so nothing aliases
   always_comb begin
      accept    = req_valid & req_ready;
      word_addr = req_addr >> BOFF;
      req_err   = ((req_addr & OFF_MASK) != '0) | (word_addr >= ADDR_W'(DEPTH));
      req_idx   = word_addr[IDX_W-1:0];
      rd_word   = mem_q[req_idx];
   end

   // Response pipeline: data is zeroed at entry so idle, write and error slots carry no data
   always_comb begin
      pipe_vld_d    = '0;
      pipe_err_d    = '0;
      pipe_vld_d[0] = accept;
      pipe_err_d[0] = accept & req_err;
      pipe_dat_d[0] = (accept & ~req_we & ~req_err) ? rd_word : '0;
      for (int s = 1; s < RD_LAT; s++) begin
         pipe_vld_d[s] = pipe_vld_q[s-1];
         pipe_err_d[s] = pipe_err_q[s-1];
         pipe_dat_d[s] = pipe_dat_q[s-1];
      end
   end

   // Control and pipeline registers; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         pipe_vld_q <= '0;
         pipe_err_q <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            pipe_dat_q[s] <= '0;
         end
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_err_q <= pipe_err_d;
         for (int s = 0; s < RD_LAT; s++) begin
            pipe_dat_q[s] <= pipe_dat_d[s];
         end
      end
   end

   // Storage array: clear sweep or a strobed write; nothing commits while reset is held
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
         end else if (accept & req_we & ~req_err) begin
            for (int b = 0; b < BYTES; b++) begin
               if (req_be[b]) begin
                  mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   assign rsp_valid = pipe_vld_q[RD_LAT-1];
   assign rsp_err   = pipe_err_q[RD_LAT-1];
   assign rsp_rdata = pipe_dat_q[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined.
// Three instances share one stimulus stream, with read latencies of 1, 2 and 4.
// Expected responses come from a byte-level memory model.
// Each instance has a monitor that retires them.
module tb_data_memory_pipelined;

   localparam int DEPTH = 64;
   localparam int NI    = 3;

   typedef struct {
      int          acc;
      logic        err;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_be = '0;

   logic [NI-1:0] rdy, rv, re;
   logic [63:0]   rd [NI];

   exp_t        exp_q [NI][$];
   logic [63:0] ref_mem [DEPTH];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   // Edge counter used to timestamp accepts and due responses
   always @(posedge clk) cyc++;

   function automatic int lat_of(int g);
      return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
   endfunction

   function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at edge %0d", name, got, exp, cyc);
      end
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

      data_memory_pipelined #(
         .WIDTH  (64),
         .DEPTH  (DEPTH),
         .ADDR_W (64),
         .RD_LAT (LAT)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid),
         .req_ready (rdy[g]),
         .req_we    (req_we),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .req_be    (req_be),
         .rsp_valid (rv[g]),
         .rsp_rdata (rd[g]),
         .rsp_err   (re[g])
      );

      // Monitor: a response due at the coming edge must be presented now, and nothing else may be
      always @(negedge clk) begin : mon
         exp_t e;
         if (exp_q[g].size() > 0 && exp_q[g][0].acc + LAT == cyc + 1) begin
            e = exp_q[g].pop_front();
            check($sformatf("lat%0d rsp_valid", LAT), 64'(rv[g]), 64'd1);
            check($sformatf("lat%0d rsp_err", LAT), 64'(re[g]), 64'(e.err));
            check($sformatf("lat%0d rsp_rdata", LAT), rd[g], e.data);
         end else begin
            check($sformatf("lat%0d idle rsp_valid", LAT), 64'(rv[g]), 64'd0);
            check($sformatf("lat%0d idle rsp_rdata", LAT), rd[g], 64'd0);
            check($sformatf("lat%0d idle rsp_err", LAT), 64'(re[g]), 64'd0);
         end
      end
   end

   task automatic idle(int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one request for one cycle; the model decides the response before memory changes
   task automatic issue(logic we, logic [63:0] addr, logic [63:0] wdata, logic [7:0] be);
      exp_t        e;
      logic [63:0] idx;
      for (int g = 0; g < NI; g++) check($sformatf("req_ready%0d", g), 64'(rdy[g]), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      idx       = addr / 8;
      e.acc     = cyc + 1;
      e.err     = (addr % 8 != 0) || (idx >= 64'(DEPTH));
      e.data    = '0;
      if (!e.err) begin
         if (we) begin
            for (int b = 0; b < 8; b++) begin
               if (be[b]) ref_mem[int'(idx)][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            e.data = ref_mem[int'(idx)];
         end
      end
      for (int g = 0; g < NI; g++) exp_q[g].push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Reset: responses due after the reset edge are dropped, then the clear sweep is timed
   task automatic apply_reset(int ncyc);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      for (int g = 0; g < NI; g++) begin
         while (exp_q[g].size() > 0 && exp_q[g][$].acc + lat_of(g) > cyc + 1) begin
            void'(exp_q[g].pop_back());
         end
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      repeat (ncyc) begin
         @(posedge clk);
         #1;
      end
      for (int g = 0; g < NI; g++) begin
         check($sformatf("reset req_ready%0d", g), 64'(rdy[g]), 64'd0);
         check($sformatf("reset rsp_valid%0d", g), 64'(rv[g]), 64'd0);
         check($sformatf("reset rsp_err%0d", g), 64'(re[g]), 64'd0);
         check($sformatf("reset rsp_rdata%0d", g), rd[g], 64'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         for (int g = 0; g < NI; g++) begin
            check($sformatf("clear req_ready%0d c%0d", g, i), 64'(rdy[g]), 64'(i == DEPTH));
         end
         if (i < DEPTH) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [63:0] a;
      int          kind;
      #1;
      apply_reset(3);

      // Every word reads back zero after the clear sweep
      for (int i = 0; i < DEPTH; i++) issue(1'b0, 64'(i * 8), '0, '0);
      idle(5);

      // Full write then immediate read of the same word, then a partial-strobe overwrite
      issue(1'b1, 64'h10, 64'h1122334455667788, 8'hFF);
      issue(1'b0, 64'h10, '0, '0);
      issue(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      issue(1'b0, 64'h10, '0, '0);
      issue(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      issue(1'b0, 64'h10, '0, '0);
      idle(3);

      // Misaligned, just past the end, and writes past the end must not touch word 0
      issue(1'b1, 64'h0, 64'h5555555555555555, 8'hFF);
      issue(1'b0, 64'h13, '0, '0);
      issue(1'b0, 64'h200, '0, '0);
      issue(1'b1, 64'h200, 64'hDEADBEEFCAFEF00D, 8'hFF);
      issue(1'b1, 64'h1_0000_0000, 64'h0123456789ABCDEF, 8'hFF);
      issue(1'b0, 64'h0, '0, '0);
      issue(1'b0, 64'h1F8, '0, '0);
      idle(4);

      // Eight back-to-back reads
      for (int i = 0; i < 8; i++) issue(1'b0, 64'(8 * (i % 3) + 8), '0, '0);
      idle(5);

      // Random mix with occasional gaps, a small hot set of words and some bad addresses
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         if (kind < 5)       a = 64'($urandom_range(0, 3) * 8);
         else if (kind < 7)  a = 64'($urandom_range(0, DEPTH - 1) * 8);
         else if (kind == 7) a = 64'($urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7));
         else if (kind == 8) a = (64'd1 << (32 + $urandom_range(0, 31))) | 64'($urandom_range(0, 3) * 8);
         else                a = 64'(DEPTH * 8 + $urandom_range(0, 15) * 8);
         issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(5);

      // Reset with two reads in flight: no stale responses, clear runs again
      issue(1'b1, 64'h20, 64'hCAFEBABE12345678, 8'hFF);
      issue(1'b0, 64'h20, '0, '0);
      issue(1'b0, 64'h10, '0, '0);
      apply_reset(2);
      issue(1'b0, 64'h20, '0, '0);
      issue(1'b0, 64'h10, '0, '0);
      idle(8);

      for (int g = 0; g < NI; g++) begin
         check($sformatf("lat%0d leftover responses", lat_of(g)), 64'(exp_q[g].size()), 64'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
